serial_bus_sequencer: RTL and testbench
=======================================

SERIAL_BUS_SEQUENCER -- requirements
Module: serial_bus_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 16: PC/MAR width in bits.
REQ-002 SHALL have parameter DATA_W, default 16: MDR width in bits.
REQ-003 SHALL have parameter INSTR_W, default 16: instruction width in bits.
REQ-004 SHALL have parameter BUS_W, default 8: serial bus bits moved per beat; ADDR_W, DATA_W, INSTR_W integer multiples of BUS_W.
REQ-005 SHALL have parameter MAX_RETRY, default 3: retries allowed per phase, range 1..15.
REQ-006 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-007 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-008 SHALL have ports is_load, is_store, input, 1 each: decoded M-type load/store of current instruction.
REQ-009 SHALL have ports ard_receive_ready, ard_data_ready, error, input, 1 each: host ready-for-instruction, host read-data ready, bus transfer error.
REQ-010 SHALL have ports go, mar_load, mdr_load, input-free outputs, 1 each: execute strobe, MAR capture, MDR capture.
REQ-011 SHALL have ports pc_shift_out, mar_shift_out, mdr_shift_out, mdr_shift_in, instr_shift_in, output, 1 each: per-beat shift enables.
REQ-012 SHALL have ports bus_pc, bus_mar, bus_mdr, output, 1 each: bus driver select, at most one high.
REQ-013 SHALL have ports busy, fault, output, 1 each; retry_cnt, output, 4: retries used in current phase.

Function
REQ-014 SHALL implement states PC_OUT, WAIT_INSTR, INSTR_IN, EXEC, ST_ADDR, ST_DATA, LD_ADDR, LD_WAIT, LD_DATA, FAULT with a beat counter cleared on every state entry.
REQ-015 SHALL in PC_OUT assert pc_shift_out and bus_pc for ADDR_W/BUS_W cycles, then enter WAIT_INSTR.
REQ-016 SHALL hold WAIT_INSTR with all strobes low until ard_receive_ready is sampled high, then enter INSTR_IN next cycle.
REQ-017 SHALL in INSTR_IN assert instr_shift_in for INSTR_W/BUS_W cycles, then enter EXEC.
REQ-018 SHALL in EXEC assert go for exactly one cycle, clear retry_cnt, and branch: is_load -> LD_ADDR with mar_load; else is_store -> ST_ADDR with mar_load and mdr_load; else -> PC_OUT; is_load wins when both high.
REQ-019 SHALL in ST_ADDR assert mar_shift_out and bus_mar for ADDR_W/BUS_W cycles, then ST_DATA with mdr_shift_out and bus_mdr for DATA_W/BUS_W cycles, then PC_OUT.
REQ-020 SHALL in LD_ADDR assert mar_shift_out and bus_mar for ADDR_W/BUS_W cycles, then LD_WAIT until ard_data_ready sampled high, then LD_DATA with mdr_shift_in for DATA_W/BUS_W cycles, then PC_OUT.
REQ-021 SHALL sample error only in shift states (PC_OUT, INSTR_IN, ST_ADDR, ST_DATA, LD_ADDR, LD_DATA); error in wait states and EXEC is ignored.
REQ-022 SHALL give error priority over beat completion when both occur in the same cycle.
REQ-023 SHALL assert busy in every state except WAIT_INSTR, LD_WAIT and FAULT.
REQ-024 SHALL in FAULT drive all strobes and bus selects low, fault high, and remain until reset.
REQ-025 SHALL never assert more than one of bus_pc, bus_mar, bus_mdr in any cycle.

Reset
REQ-026 SHALL on rst_n low force state PC_OUT, beat counter 0, retry_cnt 0, and all outputs 0 asynchronously.
REQ-027 SHALL begin PC_OUT beat 0 on the first rising clk after rst_n deasserts, abandoning any transfer in progress.

Configuration
REQ-028 SHALL, with SEQ_RETRY_EN defined, on sampled error restart the current shift state from beat 0 (re-issuing mar_load/mdr_load is not done; registers hold), increment retry_cnt, and enter FAULT when error occurs with retry_cnt equal to MAX_RETRY.
REQ-029 SHALL, with SEQ_RETRY_EN undefined, enter FAULT on the cycle after any sampled error, with retry_cnt tied to 0.

Verification (defaults: 2 beats per field)
REQ-030 SHALL cover non-memory op, ard_receive_ready high: release reset -> pc_shift_out cycles 0-1, WAIT_INSTR cycle 2, instr_shift_in cycles 3-4, go cycle 5, pc_shift_out cycle 6.
REQ-031 SHALL cover store: EXEC with is_store=1 -> mar_load=mdr_load=1 same cycle as go, 2 bus_mar cycles, 2 bus_mdr cycles, then PC_OUT.
REQ-032 SHALL cover load with ard_data_ready delayed 5 cycles -> LD_WAIT held 5 cycles with busy=0, then 2 mdr_shift_in cycles, then PC_OUT.
REQ-033 SHALL cover retry (SEQ_RETRY_EN): error on ST_DATA beat 1 -> ST_DATA restarts at beat 0, retry_cnt=1; 4 consecutive errors -> FAULT, fault=1.
REQ-034 SHALL cover no-retry build: error on PC_OUT beat 0 -> FAULT next cycle, all strobes 0, retry_cnt=0.
REQ-035 SHALL cover rst_n low mid-LD_DATA -> outputs 0 immediately; after release pc_shift_out asserted first cycle.

Source files
------------

// File: rtl/serial_bus_sequencer.sv
// Serial-bus fetch/execute sequencer: shifts PC out, instruction in, then MAR/MDR for memory ops.
// Optional macro SEQ_RETRY_EN enables per-phase retry on bus error; otherwise any error faults.
module serial_bus_sequencer #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16,
    parameter int INSTR_W   = 16,
    parameter int BUS_W     = 8,
    parameter int MAX_RETRY = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       is_load,
    input  logic       is_store,
    input  logic       ard_receive_ready,
    input  logic       ard_data_ready,
    input  logic       error,
    output logic       go,
    output logic       mar_load,
    output logic       mdr_load,
    output logic       pc_shift_out,
    output logic       mar_shift_out,
    output logic       mdr_shift_out,
    output logic       mdr_shift_in,
    output logic       instr_shift_in,
    output logic       bus_pc,
    output logic       bus_mar,
    output logic       bus_mdr,
    output logic       busy,
    output logic       fault,
    output logic [3:0] retry_cnt
);

    localparam int ADDR_BEATS  = ADDR_W / BUS_W;
    localparam int DATA_BEATS  = DATA_W / BUS_W;
    localparam int INSTR_BEATS = INSTR_W / BUS_W;
    localparam int MAX_AD      = (ADDR_BEATS > DATA_BEATS) ? ADDR_BEATS : DATA_BEATS;
    localparam int MAX_BEATS   = (MAX_AD > INSTR_BEATS) ? MAX_AD : INSTR_BEATS;
    localparam int BEAT_W      = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;

    typedef enum logic [3:0] {
        S_PC_OUT, S_WAIT_INSTR, S_INSTR_IN, S_EXEC, S_ST_ADDR,
        S_ST_DATA, S_LD_ADDR, S_LD_WAIT, S_LD_DATA, S_FAULT
    } state_t;

    state_t              r_state;
    logic [BEAT_W-1:0]   r_beat;
    logic [3:0]          r_retry;
    logic                r_run;
    logic                r_go, r_pc_ph, r_mar_ph, r_mdr_out, r_mdr_in, r_instr_in, r_busy, r_fault;

    state_t              w_state_nxt;
    state_t              w_done_state;
    logic [BEAT_W-1:0]   w_beat_nxt;
    logic [BEAT_W-1:0]   w_last_beat;
    logic [3:0]          w_retry_nxt;
    logic                w_is_shift;

    // Per-shift-state beat length and successor state.
    always_comb begin
        w_is_shift   = 1'b1;
        w_last_beat  = {BEAT_W{1'b0}};
        w_done_state = S_PC_OUT;
        case (r_state)
            S_PC_OUT:   begin w_last_beat = BEAT_W'(ADDR_BEATS - 1);  w_done_state = S_WAIT_INSTR; end
            S_INSTR_IN: begin w_last_beat = BEAT_W'(INSTR_BEATS - 1); w_done_state = S_EXEC;       end
            S_ST_ADDR:  begin w_last_beat = BEAT_W'(ADDR_BEATS - 1);  w_done_state = S_ST_DATA;    end
            S_ST_DATA:  begin w_last_beat = BEAT_W'(DATA_BEATS - 1);  w_done_state = S_PC_OUT;     end
            S_LD_ADDR:  begin w_last_beat = BEAT_W'(ADDR_BEATS - 1);  w_done_state = S_LD_WAIT;    end
            S_LD_DATA:  begin w_last_beat = BEAT_W'(DATA_BEATS - 1);  w_done_state = S_PC_OUT;     end
            default:    begin w_is_shift = 1'b0; end
        endcase
    end

    // Next-state, beat and retry computation; error outranks beat completion.
    always_comb begin
        w_state_nxt = r_state;
        w_beat_nxt  = r_beat;
        w_retry_nxt = r_retry;
        if (!r_run) begin
            w_state_nxt = S_PC_OUT;
        end else if (w_is_shift) begin
            if (error) begin
`ifdef SEQ_RETRY_EN
                if (r_retry == 4'(MAX_RETRY)) begin
                    w_state_nxt = S_FAULT;
                    w_beat_nxt  = {BEAT_W{1'b0}};
                end else begin
                    w_beat_nxt  = {BEAT_W{1'b0}};
                    w_retry_nxt = r_retry + 4'd1;
                end
`else
                w_state_nxt = S_FAULT;
                w_beat_nxt  = {BEAT_W{1'b0}};
`endif
            end else if (r_beat == w_last_beat) begin
                w_state_nxt = w_done_state;
                w_beat_nxt  = {BEAT_W{1'b0}};
                w_retry_nxt = 4'd0;
            end else begin
                w_beat_nxt = r_beat + BEAT_W'(1);
            end
        end else begin
            case (r_state)
                S_WAIT_INSTR: begin
                    if (ard_receive_ready) begin
                        w_state_nxt = S_INSTR_IN;
                    end else begin
                        w_state_nxt = S_WAIT_INSTR;
                    end
                end
                S_EXEC: begin
                    w_retry_nxt = 4'd0;
                    w_beat_nxt  = {BEAT_W{1'b0}};
                    if (is_load) begin
                        w_state_nxt = S_LD_ADDR;
                    end else if (is_store) begin
                        w_state_nxt = S_ST_ADDR;
                    end else begin
                        w_state_nxt = S_PC_OUT;
                    end
                end
                S_LD_WAIT: begin
                    if (ard_data_ready) begin
                        w_state_nxt = S_LD_DATA;
                    end else begin
                        w_state_nxt = S_LD_WAIT;
                    end
                end
                S_FAULT: w_state_nxt = S_FAULT;
                default: w_state_nxt = S_PC_OUT;
            endcase
        end
    end

    // State register; outputs are registered from the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_PC_OUT;
            r_beat     <= {BEAT_W{1'b0}};
            r_retry    <= 4'd0;
            r_run      <= 1'b0;
            r_go       <= 1'b0;
            r_pc_ph    <= 1'b0;
            r_mar_ph   <= 1'b0;
            r_mdr_out  <= 1'b0;
            r_mdr_in   <= 1'b0;
            r_instr_in <= 1'b0;
            r_busy     <= 1'b0;
            r_fault    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_beat     <= w_beat_nxt;
            r_retry    <= w_retry_nxt;
            r_run      <= 1'b1;
            r_go       <= (w_state_nxt == S_EXEC);
            r_pc_ph    <= (w_state_nxt == S_PC_OUT);
            r_mar_ph   <= (w_state_nxt == S_ST_ADDR) || (w_state_nxt == S_LD_ADDR);
            r_mdr_out  <= (w_state_nxt == S_ST_DATA);
            r_mdr_in   <= (w_state_nxt == S_LD_DATA);
            r_instr_in <= (w_state_nxt == S_INSTR_IN);
            r_busy     <= !((w_state_nxt == S_WAIT_INSTR) || (w_state_nxt == S_LD_WAIT) ||
                            (w_state_nxt == S_FAULT));
            r_fault    <= (w_state_nxt == S_FAULT);
        end
    end

    // Capture strobes follow the decode seen during the single EXEC cycle.
    assign go             = r_go;
    assign mar_load       = r_go & (is_load | is_store);
    assign mdr_load       = r_go & ~is_load & is_store;
    assign pc_shift_out   = r_pc_ph;
    assign bus_pc         = r_pc_ph;
    assign mar_shift_out  = r_mar_ph;
    assign bus_mar        = r_mar_ph;
    assign mdr_shift_out  = r_mdr_out;
    assign bus_mdr        = r_mdr_out;
    assign mdr_shift_in   = r_mdr_in;
    assign instr_shift_in = r_instr_in;
    assign busy           = r_busy;
    assign fault          = r_fault;
    assign retry_cnt      = r_retry;

endmodule

// File: tb/tb_serial_bus_sequencer.sv
// Directed scoreboard bench for serial_bus_sequencer at default widths (2 beats per field).
module tb_serial_bus_sequencer;

    logic       clk = 1'b0;
    logic       rst_n, is_load, is_store, ard_receive_ready, ard_data_ready, error;
    logic       go, mar_load, mdr_load, pc_shift_out, mar_shift_out, mdr_shift_out;
    logic       mdr_shift_in, instr_shift_in, bus_pc, bus_mar, bus_mdr, busy, fault;
    logic [3:0] retry_cnt;
    logic [12:0] obs;

    typedef struct {
        string       tag;
        logic [12:0] outs;
        logic [3:0]  retry;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    // bit order: go mar_load mdr_load pc_so mar_so mdr_so mdr_si instr_si bus_pc bus_mar bus_mdr busy fault
    localparam logic [12:0] IDLE = 13'd0;
    localparam logic [12:0] PCO  = (13'd1 << 9) | (13'd1 << 4) | (13'd1 << 1);
    localparam logic [12:0] INS  = (13'd1 << 5) | (13'd1 << 1);
    localparam logic [12:0] EXN  = (13'd1 << 12) | (13'd1 << 1);
    localparam logic [12:0] EXS  = (13'd1 << 12) | (13'd1 << 11) | (13'd1 << 10) | (13'd1 << 1);
    localparam logic [12:0] EXL  = (13'd1 << 12) | (13'd1 << 11) | (13'd1 << 1);
    localparam logic [12:0] MAR  = (13'd1 << 8) | (13'd1 << 3) | (13'd1 << 1);
    localparam logic [12:0] MDO  = (13'd1 << 7) | (13'd1 << 2) | (13'd1 << 1);
    localparam logic [12:0] MDI  = (13'd1 << 6) | (13'd1 << 1);
    localparam logic [12:0] FLT  = 13'd1;

    serial_bus_sequencer dut (
        .clk(clk), .rst_n(rst_n), .is_load(is_load), .is_store(is_store),
        .ard_receive_ready(ard_receive_ready), .ard_data_ready(ard_data_ready), .error(error),
        .go(go), .mar_load(mar_load), .mdr_load(mdr_load), .pc_shift_out(pc_shift_out),
        .mar_shift_out(mar_shift_out), .mdr_shift_out(mdr_shift_out), .mdr_shift_in(mdr_shift_in),
        .instr_shift_in(instr_shift_in), .bus_pc(bus_pc), .bus_mar(bus_mar), .bus_mdr(bus_mdr),
        .busy(busy), .fault(fault), .retry_cnt(retry_cnt)
    );

    always #5 clk = ~clk;

    assign obs = {go, mar_load, mdr_load, pc_shift_out, mar_shift_out, mdr_shift_out,
                  mdr_shift_in, instr_shift_in, bus_pc, bus_mar, bus_mdr, busy, fault};

    task automatic chk(input string tag, input logic [12:0] o, input logic [3:0] r);
        exp_t e;
        exp_t x;
        e.tag = tag; e.outs = o; e.retry = r;
        sb.push_back(e);
        #1;
        x = sb.pop_front();
        n_assert++;
        assert (obs === x.outs) else begin
            n_fail++;
            $error("FAIL %s outputs: observed %b expected %b", x.tag, obs, x.outs);
        end
        n_assert++;
        assert (retry_cnt === x.retry) else begin
            n_fail++;
            $error("FAIL %s retry_cnt: observed %0d expected %0d", x.tag, retry_cnt, x.retry);
        end
        n_assert++;
        assert ($onehot0({bus_pc, bus_mar, bus_mdr})) else begin
            n_fail++;
            $error("FAIL %s bus_select: observed %b expected at most one high", x.tag,
                   {bus_pc, bus_mar, bus_mdr});
        end
    endtask

    task automatic step(input string tag, input logic [12:0] o, input logic [3:0] r,
                        input logic err, input logic rr, input logic dr,
                        input logic ld, input logic st);
        error = err; ard_receive_ready = rr; ard_data_ready = dr; is_load = ld; is_store = st;
        chk(tag, o, r);
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0; error = 1'b0; ard_receive_ready = 1'b0; ard_data_ready = 1'b0;
        is_load = 1'b0; is_store = 1'b0;
        @(posedge clk); #1;
        chk("reset", IDLE, 4'd0);
        @(posedge clk); #1;
        chk("reset_hold", IDLE, 4'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // non-memory instruction, receive-ready already high
        step("nop_pc0",  PCO,  4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step("nop_pc1",  PCO,  4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step("nop_wait", IDLE, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step("nop_ins0", INS,  4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("nop_ins1", INS,  4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("nop_exec", EXN,  4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // store, with one extra cycle of waiting for the host
        step("st_pc0",   PCO,  4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("st_pc1",   PCO,  4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("st_wait0", IDLE, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("st_wait1", IDLE, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step("st_ins0",  INS,  4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("st_ins1",  INS,  4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("st_exec",  EXS,  4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step("st_mar0",  MAR,  4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("st_mar1",  MAR,  4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("st_mdr0",  MDO,  4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("st_mdr1",  MDO,  4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // load with both decodes high (load wins), data ready after 5 wait cycles
        step("ld_pc0",   PCO,  4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step("ld_pc1",   PCO,  4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step("ld_wait",  IDLE, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step("ld_ins0",  INS,  4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("ld_ins1",  INS,  4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("ld_exec",  EXL,  4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        step("ld_mar0",  MAR,  4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("ld_mar1",  MAR,  4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step("ld_dwait", IDLE, 4'd0, 1'b0, 1'b0, (i == 4), 1'b0, 1'b0);
        end
        step("ld_mdr0",  MDI,  4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("ld_mdr1",  MDI,  4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // error in wait states and EXEC is ignored
        step("ig_pc0",   PCO,  4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("ig_pc1",   PCO,  4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("ig_wait0", IDLE, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step("ig_wait1", IDLE, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step("ig_ins0",  INS,  4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("ig_ins1",  INS,  4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("ig_exec",  EXN,  4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // reset asserted in the middle of LD_DATA
        step("rl_pc0",   PCO,  4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step("rl_pc1",   PCO,  4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step("rl_wait",  IDLE, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step("rl_ins0",  INS,  4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("rl_ins1",  INS,  4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("rl_exec",  EXL,  4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step("rl_mar0",  MAR,  4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("rl_mar1",  MAR,  4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("rl_dwait", IDLE, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        error = 1'b0; ard_receive_ready = 1'b0; ard_data_ready = 1'b0; is_load = 1'b0; is_store = 1'b0;
        chk("rl_mdr0", MDI, 4'd0);
        rst_n = 1'b0;
        chk("rst_async", IDLE, 4'd0);
        @(posedge clk); #1;
        chk("rst_held", IDLE, 4'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

`ifdef SEQ_RETRY_EN
        // single error in ST_DATA beat 1: restart at beat 0 then complete
        step("rt_pc0",   PCO,  4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step("rt_pc1",   PCO,  4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step("rt_wait",  IDLE, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step("rt_ins0",  INS,  4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("rt_ins1",  INS,  4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("rt_exec",  EXS,  4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step("rt_mar0",  MAR,  4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("rt_mar1",  MAR,  4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("rt_mdr0",  MDO,  4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("rt_mdr1e", MDO,  4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step("rt_rb0",   MDO,  4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("rt_rb1",   MDO,  4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        // four consecutive errors exhaust the retries
        step("rf_pc0",   PCO,  4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step("rf_pc1",   PCO,  4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step("rf_wait",  IDLE, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step("rf_ins0",  INS,  4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("rf_ins1",  INS,  4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("rf_exec",  EXS,  4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step("rf_mar0",  MAR,  4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("rf_mar1",  MAR,  4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("rf_err0",  MDO,  4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step("rf_err1",  MDO,  4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step("rf_err2",  MDO,  4'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step("rf_err3",  MDO,  4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step("rf_fault", FLT,  4'd3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        step("rf_hold",  FLT,  4'd3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
`else
        // any error in a shift state faults immediately
        step("nr_pc0e",  PCO,  4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step("nr_fault", FLT,  4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        step("nr_hold0", FLT,  4'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        step("nr_hold1", FLT,  4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
